// File: rtl/mips_exe_pkg.sv
// Shared definitions for the MIPS execute stage: ALU operation codes and the
// multiply/divide sequencer state encoding.
package mips_exe_pkg;

  localparam int ALU_ADD   = 0;
  localparam int ALU_ADDU  = 1;
  localparam int ALU_SUB   = 2;
  localparam int ALU_SUBU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_OR    = 5;
  localparam int ALU_XOR   = 6;
  localparam int ALU_NOR   = 7;
  localparam int ALU_SLT   = 8;
  localparam int ALU_SLTU  = 9;
  localparam int ALU_SLL   = 10;
  localparam int ALU_SRL   = 11;
  localparam int ALU_SRA   = 12;
  localparam int ALU_LUI   = 13;
  localparam int ALU_MOVZ  = 14;
  localparam int ALU_MOVN  = 15;
  localparam int ALU_MULT  = 16;
  localparam int ALU_MULTU = 17;
  localparam int ALU_DIV   = 18;
  localparam int ALU_DIVU  = 19;
  localparam int ALU_MFHI  = 20;
  localparam int ALU_MFLO  = 21;
  localparam int ALU_MTHI  = 22;
  localparam int ALU_MTLO  = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) datapath with
// step counter; signed operation works on magnitudes and fixes signs at the end.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   mag_b, a_raw;
  logic               div_mode, neg_res, neg_rem, div_zero;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in, quo, rem;

  assign mag_a_in = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b_in = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // acc = {partial high word, low word}: multiplier bits shift out of the low
  // word while product bits shift in; for divide, {remainder, quotient}.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, mag_b};
    acc_next = acc;
    if (!div_mode) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mag_b    <= '0;
      a_raw    <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, mag_a_in};
      mag_b    <= mag_b_in;
      a_raw    <= op_a;
      div_mode <= is_div;
      neg_res  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_rem  <= is_signed && is_div && op_a[WIDTH-1];
      div_zero <= is_div && (op_b == '0);
      cnt      <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
    if (div_mode) begin
      hi = div_zero ? a_raw : rem;
      lo = div_zero ? '1 : quo;
    end
  end

endmodule

// File: rtl/exe_mdu_unit.sv
// MIPS execute unit: single-cycle ALU with registered result plus an iterative
// multiply/divide unit owning HI/LO. Handshake: an op is taken on a rising edge
// when in_valid && in_ready && !flush; out_valid is a one-cycle pulse, no back-pressure.
module exe_mdu_unit
  import mips_exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             equal_mov,
  output logic             overflow,
  output logic             busy
);
  localparam int SH_W = $clog2(WIDTH);

  mdu_state_t       state, state_next;
  logic [WIDTH-1:0] hi_q, lo_q, alu_res, mdu_hi, mdu_lo, sum, dif;
  logic             alu_eq, alu_ov, is_mul, is_div, is_signed, accept, step, last;
  logic [SH_W-1:0]  shamt;
  int               op_i;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign op_i     = int'(alu_op);
  assign shamt    = src_a[SH_W-1:0];
  assign sum      = src_a + src_b;
  assign dif      = src_a - src_b;
  assign is_mul   = (op_i == ALU_MULT) || (op_i == ALU_MULTU);
  assign is_div   = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
  assign is_signed = (op_i == ALU_MULT) || (op_i == ALU_DIV);
  assign step     = ((state == ST_MUL) || (state == ST_DIV)) && !flush;

  always_comb begin
    alu_res = '0;
    alu_eq  = 1'b0;
    alu_ov  = 1'b0;
    case (op_i)
      ALU_ADD: begin
        alu_res = sum;
        alu_ov  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUB: begin
        alu_res = dif;
        alu_ov  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_SUBU: alu_res = dif;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_b << shamt;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_b) >>> shamt);
      ALU_LUI:  alu_res = src_b << (WIDTH / 2);
      ALU_MOVZ: begin
        alu_res = src_a;
        alu_eq  = (src_b == '0);
      end
      ALU_MOVN: begin
        alu_res = src_a;
        alu_eq  = (src_b != '0);
      end
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      ALU_MTHI, ALU_MTLO: alu_res = src_a;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul)      state_next = ST_MUL;
        else if (accept && is_div) state_next = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (flush)     state_next = ST_IDLE;
        else if (last) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && (is_mul || is_div)),
    .is_div    (is_div),
    .is_signed (is_signed),
    .step      (step),
    .op_a      (src_a),
    .op_b      (src_b),
    .last      (last),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  // Multi-cycle ops leave the output registers alone until DONE commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      equal_mov <= 1'b0;
      overflow  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul && !is_div) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        equal_mov <= alu_eq;
        overflow  <= alu_ov;
        if (op_i == ALU_MTHI) hi_q <= src_a;
        if (op_i == ALU_MTLO) lo_q <= src_a;
      end else if ((state == ST_DONE) && !flush) begin
        out_valid <= 1'b1;
        result    <= mdu_lo;
        equal_mov <= 1'b0;
        overflow  <= 1'b0;
        hi_q      <= mdu_hi;
        lo_q      <= mdu_lo;
      end
    end
  end

endmodule
